counter_prog_tc: RTL

- Parametrised successor to the team's 8-bit loadable counter.
- Up/down binary counter with synchronous load and programmable terminal count.
- Three count modes: free-running wrap, modulo-N wrap, one-shot halt.
- Registered terminal-count pulse, sticky done flag and gated output. Drop-in timing/event counter for Tiny Tapeout tiles behind the ui_in/uio_in pin map.

---
 rtl/counter_prog_pkg.sv | 17 +
 rtl/counter_prescaler.sv | 38 +++
 rtl/counter_prog_tc.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/counter_prog_pkg.sv
// Shared types for the programmable terminal-count counter:
// count-mode encoding and the RUN/HALT control-state encoding.
package counter_prog_pkg;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_MODULO  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage : counter_prog_pkg

// File: rtl/counter_prescaler.sv
// Enable prescaler: counts enabled cycles and raises tick on the cycle where
// the count equals div, then restarts from zero. div = 0 ticks on every
// enabled cycle. Holds while en is low; clr restarts the period.
module counter_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_r;
    logic               at_div_s;

    assign at_div_s = (presc_r == div);
    assign tick     = en && at_div_s;

    // Prescale count: restart on clr or on a tick, advance on enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= {PRESC_W{1'b0}};
        end else if (clr) begin
            presc_r <= {PRESC_W{1'b0}};
        end else if (en) begin
            if (at_div_s) begin
                presc_r <= {PRESC_W{1'b0}};
            end else begin
                presc_r <= presc_r + {{(PRESC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            presc_r <= presc_r;
        end
    end

endmodule : counter_prescaler

// File: rtl/counter_prog_tc.sv
// Up/down counter with synchronous load, programmable terminal value and
// FREE / MODULO / ONESHOT modes. Registered terminal-count pulse and sticky
// one-shot done flag; q is forced to zero when oe is low.
// Optional build macro: CTR_PRESCALE_EN adds an enable prescaler so the
// counter steps once per presc_div+1 enabled cycles.
module counter_prog_tc
    import counter_prog_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               up_dn,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   tc_val,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic               oe,
    output logic [WIDTH-1:0]   q,
    output logic               tc_pulse,
    output logic               done
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_r;
    state_e           state_r;
    logic             done_r;
    logic             tc_pulse_r;

    logic [WIDTH-1:0] cnt_nxt_s;
    state_e           state_nxt_s;
    logic             done_nxt_s;
    logic             tc_nxt_s;

    mode_e            mode_s;
    logic [WIDTH-1:0] lim_s;
    logic             at_tc_s;
    logic             run_s;
    logic             step_s;

    assign mode_s = mode_e'(mode);
    assign run_s  = (state_r == ST_RUN);

`ifdef CTR_PRESCALE_EN
    logic tick_s;

    counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (en && run_s),
        .div  (presc_div),
        .tick (tick_s)
    );

    assign step_s = en && run_s && tick_s;
`else
    logic unused_s;

    assign unused_s = ^presc_div;
    assign step_s   = en && run_s;
`endif

    // Upper limit for up-counting: full range in FREE/reserved, tc_val otherwise.
    always_comb begin
        lim_s = CNT_ONES;
        case (mode_s)
            MODE_MODULO:  lim_s = tc_val;
            MODE_ONESHOT: lim_s = tc_val;
            default:      lim_s = CNT_ONES;
        endcase
    end

    // Terminal detect is pure equality so an out-of-range count simply runs past.
    always_comb begin
        if (up_dn) begin
            at_tc_s = (cnt_r == lim_s);
        end else begin
            at_tc_s = (cnt_r == CNT_ZERO);
        end
    end

    // Next-state decode with priority load > step > hold.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        state_nxt_s = state_r;
        done_nxt_s  = done_r;
        tc_nxt_s    = 1'b0;
        if (load) begin
            cnt_nxt_s   = load_val;
            state_nxt_s = ST_RUN;
            done_nxt_s  = 1'b0;
        end else if (step_s) begin
            if (at_tc_s) begin
                tc_nxt_s = 1'b1;
                case (mode_s)
                    MODE_ONESHOT: begin
                        cnt_nxt_s   = cnt_r;
                        state_nxt_s = ST_HALT;
                        done_nxt_s  = 1'b1;
                    end
                    MODE_MODULO: begin
                        cnt_nxt_s = up_dn ? CNT_ZERO : tc_val;
                    end
                    default: begin
                        cnt_nxt_s = up_dn ? CNT_ZERO : CNT_ONES;
                    end
                endcase
            end else if (up_dn) begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
                cnt_nxt_s = cnt_r - CNT_ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Control FSM and registered count/flag outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= CNT_ZERO;
            state_r    <= ST_RUN;
            done_r     <= 1'b0;
            tc_pulse_r <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            state_r    <= state_nxt_s;
            done_r     <= done_nxt_s;
            tc_pulse_r <= tc_nxt_s;
        end
    end

    assign q        = oe ? cnt_r : CNT_ZERO;
    assign tc_pulse = tc_pulse_r;
    assign done     = done_r;

endmodule : counter_prog_tc
